fifo_umbrales: RTL and testbench

//  Synchronous single-clock FIFO with programmable almost-full/almost-empty thresholds.

---
 rtl/fifo_umbrales.sv | 77 +++++++
 tb/tb_fifo_umbrales.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_umbrales.sv
// fifo_umbrales: single-clock FIFO with programmable almost-full/almost-empty thresholds
module fifo_umbrales #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    input  logic [ADDR_WIDTH-1:0] umbral_alto,
    input  logic [ADDR_WIDTH-1:0] umbral_bajo,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic                  fifo_error
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  valid_q, valid_d, error_q, error_d;
    logic                  wr_en, rd_en;

    assign count        = count_q;
    assign data_out     = data_out_q;
    assign valid_out    = valid_q;
    assign fifo_error   = error_q;
    assign fifo_empty   = count_q == '0;
    assign fifo_full    = count_q == FULL_CNT;
    assign almost_empty = count_q <= {1'b0, umbral_bajo};
    assign almost_full  = umbral_alto != '0 && count_q >= {1'b0, umbral_alto};

    // Next state: a pop on a full FIFO frees the slot the simultaneous push reuses
    always_comb begin
        wr_en      = push && (!fifo_full || pop);
        rd_en      = pop && !fifo_empty;
        wr_ptr_d   = wr_en ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
        rd_ptr_d   = rd_en ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
        count_d    = (wr_en && !rd_en) ? count_q + (ADDR_WIDTH+1)'(1) :
                     (rd_en && !wr_en) ? count_q - (ADDR_WIDTH+1)'(1) : count_q;
        data_out_d = rd_en ? mem_q[rd_ptr_q] : data_out_q;
        valid_d    = rd_en;
        error_d    = error_q || (push && fifo_full && !pop) || (pop && fifo_empty);
    end

    // Control and output registers; reset discards all stored words at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            error_q    <= error_d;
        end
    end

    // Storage array, intentionally left unreset
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= data_in;
    end
endmodule

// File: tb/tb_fifo_umbrales.sv
// tb_fifo_umbrales: directed self-checking bench for fifo_umbrales (DEPTH=4)
module tb_fifo_umbrales;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       push = 1'b0;
    logic [5:0] data_in = '0;
    logic       pop = 1'b0;
    logic [1:0] umbral_alto = '0;
    logic [1:0] umbral_bajo = '0;
    logic [5:0] data_out;
    logic       valid_out;
    logic [2:0] count;
    logic       fifo_empty, fifo_full, almost_empty, almost_full, fifo_error;
    int n_checks = 0;
    int n_fail = 0;

    fifo_umbrales #(.DATA_WIDTH(6), .ADDR_WIDTH(2)) dut (
        .clk(clk), .reset(reset), .push(push), .data_in(data_in), .pop(pop),
        .umbral_alto(umbral_alto), .umbral_bajo(umbral_bajo),
        .data_out(data_out), .valid_out(valid_out), .count(count),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full),
        .almost_empty(almost_empty), .almost_full(almost_full), .fifo_error(fifo_error)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        push = 0; pop = 0; reset = 1;
        step();
        reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        if ({count, fifo_empty, fifo_full, almost_empty, almost_full, fifo_error, valid_out, data_out} !== {3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00}) begin
            $display("FAIL reset_state: got cnt=%0d e=%b f=%b ae=%b af=%b err=%b v=%b d=%h, want cnt=0 e=1 f=0 ae=1 af=0 err=0 v=0 d=00",
                     count, fifo_empty, fifo_full, almost_empty, almost_full, fifo_error, valid_out, data_out);
            n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 4; i++) begin
            push = 1; data_in = 6'(i);
            step();
            if ({count, fifo_empty, fifo_full, fifo_error} !== {3'(i), 1'b0, (i == 4), 1'b0}) begin
                $display("FAIL fill_%0d: got cnt=%0d e=%b f=%b err=%b, want cnt=%0d e=0 f=%b err=0",
                         i, count, fifo_empty, fifo_full, fifo_error, i, (i == 4));
                n_fail++;
            end
            n_checks++;
        end
        push = 0;
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 4; i++) begin
            pop = 1;
            step();
            if ({data_out, valid_out, count} !== {6'(i), 1'b1, 3'(4 - i)}) begin
                $display("FAIL drain_%0d: got d=%h v=%b cnt=%0d, want d=%h v=1 cnt=%0d",
                         i, data_out, valid_out, count, 6'(i), 4 - i);
                n_fail++;
            end
            n_checks++;
        end
        pop = 0;
        step();
        if ({fifo_empty, valid_out, data_out} !== {1'b1, 1'b0, 6'h04}) begin
            $display("FAIL drain_idle: got e=%b v=%b d=%h, want e=1 v=0 d=04", fifo_empty, valid_out, data_out);
            n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_thresholds();
        logic [1:0] exp_ae [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [1:0] exp_af [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        umbral_alto = 2'd3; umbral_bajo = 2'd1;
        for (int i = 0; i <= 3; i++) begin
            if (i > 0) begin
                push = 1; data_in = 6'(i);
                step();
                push = 0;
            end
            if ({almost_empty, almost_full} !== {exp_ae[i][0], exp_af[i][0]}) begin
                $display("FAIL thr_cnt%0d: got ae=%b af=%b, want ae=%b af=%b",
                         i, almost_empty, almost_full, exp_ae[i][0], exp_af[i][0]);
                n_fail++;
            end
            n_checks++;
        end
        umbral_alto = 2'd0; umbral_bajo = 2'd3;
        #1;
        if ({almost_empty, almost_full, count} !== {1'b1, 1'b0, 3'd3}) begin
            $display("FAIL thr_change: got ae=%b af=%b cnt=%0d, want ae=1 af=0 cnt=3", almost_empty, almost_full, count);
            n_fail++;
        end
        n_checks++;
        umbral_alto = 2'd0; umbral_bajo = 2'd0;
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            push = 1; data_in = 6'(8'h10 + i);
            step();
        end
        push = 0;
        if ({count, fifo_error, fifo_full} !== {3'd4, 1'b1, 1'b1}) begin
            $display("FAIL ovf_flag: got cnt=%0d err=%b f=%b, want cnt=4 err=1 f=1", count, fifo_error, fifo_full);
            n_fail++;
        end
        n_checks++;
        for (int i = 1; i <= 4; i++) begin
            pop = 1;
            step();
            if ({data_out, valid_out, fifo_error} !== {6'(8'h10 + i), 1'b1, 1'b1}) begin
                $display("FAIL ovf_drain_%0d: got d=%h v=%b err=%b, want d=%h v=1 err=1",
                         i, data_out, valid_out, fifo_error, 6'(8'h10 + i));
                n_fail++;
            end
            n_checks++;
        end
        pop = 0;
        if (fifo_empty !== 1'b1) begin
            $display("FAIL ovf_empty: got e=%b, want e=1", fifo_empty);
            n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_back_to_back();
        logic [5:0] exp_d [4] = '{6'h22, 6'h23, 6'h24, 6'h2A};
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            push = 1; data_in = 6'(8'h20 + i);
            step();
        end
        push = 1; pop = 1; data_in = 6'h2A;
        step();
        push = 0; pop = 0;
        if ({data_out, valid_out, count, fifo_error} !== {6'h21, 1'b1, 3'd4, 1'b0}) begin
            $display("FAIL full_pushpop: got d=%h v=%b cnt=%0d err=%b, want d=21 v=1 cnt=4 err=0",
                     data_out, valid_out, count, fifo_error);
            n_fail++;
        end
        n_checks++;
        for (int i = 0; i < 4; i++) begin
            pop = 1;
            step();
            if ({data_out, valid_out} !== {exp_d[i], 1'b1}) begin
                $display("FAIL wrap_order_%0d: got d=%h v=%b, want d=%h v=1", i, data_out, valid_out, exp_d[i]);
                n_fail++;
            end
            n_checks++;
        end
        pop = 0;
    endtask

    task automatic test_underflow_reset();
        do_reset();
        pop = 1;
        step();
        pop = 0;
        if ({fifo_error, valid_out, count} !== {1'b1, 1'b0, 3'd0}) begin
            $display("FAIL underflow: got err=%b v=%b cnt=%0d, want err=1 v=0 cnt=0", fifo_error, valid_out, count);
            n_fail++;
        end
        n_checks++;
        push = 1; pop = 1; data_in = 6'h31;
        step();
        if ({count, valid_out, fifo_error} !== {3'd1, 1'b0, 1'b1}) begin
            $display("FAIL empty_pushpop: got cnt=%0d v=%b err=%b, want cnt=1 v=0 err=1", count, valid_out, fifo_error);
            n_fail++;
        end
        n_checks++;
        pop = 0; data_in = 6'h32;
        step();
        push = 0;
        if (count !== 3'd2) begin
            $display("FAIL prefill: got cnt=%0d, want cnt=2", count);
            n_fail++;
        end
        n_checks++;
        #2 reset = 1;
        #1;
        if ({count, fifo_empty, fifo_error, valid_out} !== {3'd0, 1'b1, 1'b0, 1'b0}) begin
            $display("FAIL async_reset: got cnt=%0d e=%b err=%b v=%b, want cnt=0 e=1 err=0 v=0",
                     count, fifo_empty, fifo_error, valid_out);
            n_fail++;
        end
        n_checks++;
        step();
        reset = 0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_thresholds();
        test_overflow();
        test_back_to_back();
        test_underflow_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
